// File: rtl/cpu_mem_responder_pkg.sv
// Shared CPU/memory-responder types: access direction, bus widths and responder states.
// Pure declarations; no logic, no latency.
package cpu_mem_responder_pkg;

    localparam int CPU_ADDR_W = 16;
    localparam int CPU_DATA_W = 8;
    localparam int WAIT_CNT_W = 4;

    typedef enum logic {
        RW_READ  = 1'b0,
        RW_WRITE = 1'b1
    } rw_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } rsp_state_e;

endpackage

// File: rtl/cpu_mem_responder_if.sv
// CPU-to-memory access bus: request/direction/address/write data out, read data and strobes back.
// No timing of its own; the initiator holds the request stable until it sees ready.
interface cpu_mem_responder_if
    import cpu_mem_responder_pkg::*;
#(
    parameter int ADDR_WIDTH = CPU_ADDR_W,
    parameter int DATA_WIDTH = CPU_DATA_W
) ();

    logic                  req_rdwr;
    rw_e                   which_rdwr;
    logic [ADDR_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0] data_out;
    logic [DATA_WIDTH-1:0] data_in;
    logic                  ready;
    logic                  err;

    modport master (
        output req_rdwr, which_rdwr, addr, data_out,
        input  data_in, ready, err
    );

    modport slave (
        input  req_rdwr, which_rdwr, addr, data_out,
        output data_in, ready, err
    );

endinterface

// File: rtl/cpu_mem_array.sv
// Single-port byte array with synchronous write and registered synchronous read.
// Read data appears one edge after re and holds until the next re; no backpressure.
module cpu_mem_array #(
    parameter int AW = 16,
    parameter int DW = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          we,
    input  logic          re,
    input  logic [AW-1:0] addr,
    input  logic [DW-1:0] wdat,
    output logic [DW-1:0] rdat
);

    logic [DW-1:0] mem [2**AW];
    logic [DW-1:0] rdat_q, rdat_d;

    always_comb begin
        rdat_d = rdat_q;
        if (re) rdat_d = mem[addr];
    end

    // Only the read register is reset; the storage keeps its contents.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) rdat_q <= '0;
        else      rdat_q <= rdat_d;
    end

    always_ff @(posedge clk) begin
        if (we) mem[addr] <= wdat;
    end

    assign rdat = rdat_q;

endmodule

// File: rtl/cpu_mem_responder.sv
// Memory responder for the CPU bus; ready pulses 1+WAIT_STATES enabled edges after the request is sampled.
// One access per 2+WAIT_STATES cycles; enable=0 freezes everything; requests during RESP are ignored.
module cpu_mem_responder
    import cpu_mem_responder_pkg::*;
#(
    parameter int ADDR_WIDTH  = CPU_ADDR_W,
    parameter int DATA_WIDTH  = CPU_DATA_W,
    parameter int MEM_AW      = 16,
    parameter int WAIT_STATES = 0
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 enable,
    cpu_mem_responder_if.slave   bus
);

    rsp_state_e              state_q, state_d;
    logic [WAIT_CNT_W-1:0]   cnt_q, cnt_d;
    rw_e                     lat_rw_q, lat_rw_d;
    logic [ADDR_WIDTH-1:0]   lat_addr_q, lat_addr_d;
    logic [DATA_WIDTH-1:0]   lat_dat_q, lat_dat_d;
    logic                    ready_q, ready_d;
    logic                    err_q, err_d;
    logic                    oow_rd_q, oow_rd_d;

    logic                    acc_vld;
    rw_e                     acc_rw;
    logic [ADDR_WIDTH-1:0]   acc_addr;
    logic [DATA_WIDTH-1:0]   acc_dat;
    logic                    acc_in_win;
    logic                    mem_we, mem_re;
    logic [DATA_WIDTH-1:0]   mem_rdat;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        lat_rw_d   = lat_rw_q;
        lat_addr_d = lat_addr_q;
        lat_dat_d  = lat_dat_q;
        ready_d    = ready_q;
        err_d      = err_q;
        oow_rd_d   = oow_rd_q;
        acc_vld    = 1'b0;
        acc_rw     = lat_rw_q;
        acc_addr   = lat_addr_q;
        acc_dat    = lat_dat_q;

        if (enable) begin
            ready_d = 1'b0;
            err_d   = 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (bus.req_rdwr) begin
                        lat_rw_d   = bus.which_rdwr;
                        lat_addr_d = bus.addr;
                        lat_dat_d  = bus.data_out;
                        if (WAIT_STATES == 0) begin
                            acc_vld  = 1'b1;
                            acc_rw   = bus.which_rdwr;
                            acc_addr = bus.addr;
                            acc_dat  = bus.data_out;
                        end else begin
                            cnt_d   = WAIT_CNT_W'(WAIT_STATES - 1);
                            state_d = ST_WAIT;
                        end
                    end
                end
                ST_WAIT: begin
                    if (cnt_q == '0) acc_vld = 1'b1;
                    else             cnt_d   = cnt_q - 1'b1;
                end
                ST_RESP: state_d = ST_IDLE;
                default: state_d = ST_IDLE;
            endcase
        end

        acc_in_win = ((acc_addr >> MEM_AW) == '0);

        if (acc_vld) begin
            state_d = ST_RESP;
            ready_d = 1'b1;
            err_d   = ~acc_in_win;
            if (acc_rw == RW_READ) oow_rd_d = ~acc_in_win;
        end

        // rst gating keeps an access from slipping into the array while reset is held.
        mem_we = rst & acc_vld & acc_in_win & (acc_rw == RW_WRITE);
        mem_re = rst & acc_vld & acc_in_win & (acc_rw == RW_READ);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            lat_rw_q   <= RW_READ;
            lat_addr_q <= '0;
            lat_dat_q  <= '0;
            ready_q    <= 1'b0;
            err_q      <= 1'b0;
            oow_rd_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            lat_rw_q   <= lat_rw_d;
            lat_addr_q <= lat_addr_d;
            lat_dat_q  <= lat_dat_d;
            ready_q    <= ready_d;
            err_q      <= err_d;
            oow_rd_q   <= oow_rd_d;
        end
    end

    cpu_mem_array #(
        .AW (MEM_AW),
        .DW (DATA_WIDTH)
    ) u_array (
        .clk  (clk),
        .rst  (rst),
        .we   (mem_we),
        .re   (mem_re),
        .addr (acc_addr[MEM_AW-1:0]),
        .wdat (acc_dat),
        .rdat (mem_rdat)
    );

    // An out-of-window read returns all-ones until the next read completes.
    assign bus.data_in = oow_rd_q ? '1 : mem_rdat;
    assign bus.ready   = ready_q;
    assign bus.err     = err_q;

endmodule

// File: tb/tb_cpu_mem_responder.sv
// Directed bench for cpu_mem_responder: three instances (no wait, 3 wait states, 4 KiB window).
module tb_cpu_mem_responder;
    import cpu_mem_responder_pkg::*;

    logic clk = 1'b0;
    logic rst;
    logic enable;
    always #5 clk = ~clk;

    logic        req_a  [3];
    rw_e         rw_a   [3];
    logic [15:0] addr_a [3];
    logic [7:0]  dout_a [3];

    int total = 0;
    int bad   = 0;

    cpu_mem_responder_if #(.ADDR_WIDTH(16), .DATA_WIDTH(8)) bus0 ();
    cpu_mem_responder_if #(.ADDR_WIDTH(16), .DATA_WIDTH(8)) bus3 ();
    cpu_mem_responder_if #(.ADDR_WIDTH(16), .DATA_WIDTH(8)) busm ();

    assign bus0.req_rdwr = req_a[0];  assign bus0.which_rdwr = rw_a[0];
    assign bus0.addr     = addr_a[0]; assign bus0.data_out   = dout_a[0];
    assign bus3.req_rdwr = req_a[1];  assign bus3.which_rdwr = rw_a[1];
    assign bus3.addr     = addr_a[1]; assign bus3.data_out   = dout_a[1];
    assign busm.req_rdwr = req_a[2];  assign busm.which_rdwr = rw_a[2];
    assign busm.addr     = addr_a[2]; assign busm.data_out   = dout_a[2];

    cpu_mem_responder #(.ADDR_WIDTH(16), .DATA_WIDTH(8), .MEM_AW(16), .WAIT_STATES(0))
        dut0 (.clk(clk), .rst(rst), .enable(enable), .bus(bus0));
    cpu_mem_responder #(.ADDR_WIDTH(16), .DATA_WIDTH(8), .MEM_AW(16), .WAIT_STATES(3))
        dut3 (.clk(clk), .rst(rst), .enable(enable), .bus(bus3));
    cpu_mem_responder #(.ADDR_WIDTH(16), .DATA_WIDTH(8), .MEM_AW(12), .WAIT_STATES(0))
        dutm (.clk(clk), .rst(rst), .enable(enable), .bus(busm));

    function automatic logic rdy(input int i);
        case (i)
            0:       return bus0.ready;
            1:       return bus3.ready;
            default: return busm.ready;
        endcase
    endfunction

    function automatic logic errv(input int i);
        case (i)
            0:       return bus0.err;
            1:       return bus3.err;
            default: return busm.err;
        endcase
    endfunction

    function automatic logic [7:0] din(input int i);
        case (i)
            0:       return bus0.data_in;
            1:       return bus3.data_in;
            default: return busm.data_in;
        endcase
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issues one access on instance i and reports edges-to-ready, data, err and
    // whether any strobe was still high one cycle after ready. lat=-1 on timeout.
    task automatic do_access(input int i, input bit wr, input logic [15:0] a, input logic [7:0] d,
                             input bit scramble, output int lat, output logic [7:0] dat,
                             output logic er, output logic post);
        req_a[i]  = 1'b1;
        rw_a[i]   = wr ? RW_WRITE : RW_READ;
        addr_a[i] = a;
        dout_a[i] = d;
        lat = 0;
        for (int k = 0; k < 60; k++) begin
            tick();
            lat++;
            if (k == 0 && scramble) begin
                addr_a[i] = a ^ 16'h00FF;
                dout_a[i] = ~d;
            end
            if (rdy(i)) break;
        end
        if (!rdy(i)) lat = -1;
        dat = din(i);
        er  = errv(i);
        req_a[i] = 1'b0;
        tick();
        post = rdy(i) | errv(i);
    endtask

    task automatic test_reset();
        #2;
        for (int i = 0; i < 3; i++) begin
            total++; if (rdy(i) !== 1'b0) begin bad++; $display("FAIL reset_ready[%0d] got=%b want=0", i, rdy(i)); end
            total++; if (errv(i) !== 1'b0) begin bad++; $display("FAIL reset_err[%0d] got=%b want=0", i, errv(i)); end
            total++; if (din(i) !== 8'h00) begin bad++; $display("FAIL reset_data[%0d] got=%h want=00", i, din(i)); end
        end
        tick();
        rst = 1'b1;
        tick();
    endtask

    task automatic test_nowait();
        logic [15:0] ta [4] = '{16'hF000, 16'hF500, 16'hF000, 16'hF500};
        bit          tw [4] = '{1'b1, 1'b1, 1'b0, 1'b0};
        logic [7:0]  td [4] = '{8'h45, 8'h87, 8'h00, 8'h00};
        logic [7:0]  te [4] = '{8'h00, 8'h00, 8'h45, 8'h87};
        int lat; logic [7:0] dat; logic er, post;
        for (int n = 0; n < 4; n++) begin
            do_access(0, tw[n], ta[n], td[n], 1'b0, lat, dat, er, post);
            total++; if (lat !== 1) begin bad++; $display("FAIL nowait_lat[%0d] got=%0d want=1", n, lat); end
            total++; if (dat !== te[n]) begin bad++; $display("FAIL nowait_data[%0d] got=%h want=%h", n, dat, te[n]); end
            total++; if (er !== 1'b0) begin bad++; $display("FAIL nowait_err[%0d] got=%b want=0", n, er); end
            total++; if (post !== 1'b0) begin bad++; $display("FAIL nowait_pulse[%0d] got=%b want=0", n, post); end
        end
    endtask

    task automatic test_wait3();
        logic [15:0] ta [5] = '{16'h12CB, 16'h1234, 16'h1234, 16'h0020, 16'h0020};
        bit          tw [5] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
        logic [7:0]  td [5] = '{8'h3C, 8'hA5, 8'h00, 8'h77, 8'h00};
        bit          ts [5] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
        logic [7:0]  te [5] = '{8'h00, 8'h00, 8'hA5, 8'hA5, 8'h77};
        int lat; logic [7:0] dat; logic er, post;
        for (int n = 0; n < 5; n++) begin
            do_access(1, tw[n], ta[n], td[n], ts[n], lat, dat, er, post);
            total++; if (lat !== 4) begin bad++; $display("FAIL wait3_lat[%0d] got=%0d want=4", n, lat); end
            total++; if (dat !== te[n]) begin bad++; $display("FAIL wait3_data[%0d] got=%h want=%h", n, dat, te[n]); end
            total++; if (er !== 1'b0) begin bad++; $display("FAIL wait3_err[%0d] got=%b want=0", n, er); end
            total++; if (post !== 1'b0) begin bad++; $display("FAIL wait3_pulse[%0d] got=%b want=0", n, post); end
        end
    endtask

    task automatic test_window();
        logic [15:0] ta [4] = '{16'h0000, 16'hF000, 16'hF000, 16'h0000};
        bit          tw [4] = '{1'b1, 1'b0, 1'b1, 1'b0};
        logic [7:0]  td [4] = '{8'h22, 8'h00, 8'h11, 8'h00};
        logic [7:0]  te [4] = '{8'h00, 8'hFF, 8'hFF, 8'h22};
        logic        tr [4] = '{1'b0, 1'b1, 1'b1, 1'b0};
        int lat; logic [7:0] dat; logic er, post;
        for (int n = 0; n < 4; n++) begin
            do_access(2, tw[n], ta[n], td[n], 1'b0, lat, dat, er, post);
            total++; if (lat !== 1) begin bad++; $display("FAIL window_lat[%0d] got=%0d want=1", n, lat); end
            total++; if (dat !== te[n]) begin bad++; $display("FAIL window_data[%0d] got=%h want=%h", n, dat, te[n]); end
            total++; if (er !== tr[n]) begin bad++; $display("FAIL window_err[%0d] got=%b want=%b", n, er, tr[n]); end
            total++; if (post !== 1'b0) begin bad++; $display("FAIL window_pulse[%0d] got=%b want=0", n, post); end
        end
    endtask

    task automatic test_reset_in_wait();
        int lat; logic [7:0] dat; logic er, post;
        do_access(1, 1'b1, 16'h0010, 8'h5A, 1'b0, lat, dat, er, post);
        do_access(1, 1'b0, 16'h0010, 8'h00, 1'b0, lat, dat, er, post);
        total++; if (dat !== 8'h5A) begin bad++; $display("FAIL rstwait_pre got=%h want=5a", dat); end
        req_a[1] = 1'b1; rw_a[1] = RW_WRITE; addr_a[1] = 16'h0010; dout_a[1] = 8'h99;
        tick();
        tick();
        rst = 1'b0;
        #1;
        total++; if (rdy(1) !== 1'b0) begin bad++; $display("FAIL rstwait_ready got=%b want=0", rdy(1)); end
        total++; if (errv(1) !== 1'b0) begin bad++; $display("FAIL rstwait_err got=%b want=0", errv(1)); end
        total++; if (din(1) !== 8'h00) begin bad++; $display("FAIL rstwait_data got=%h want=00", din(1)); end
        req_a[1] = 1'b0;
        tick();
        rst = 1'b1;
        tick();
        do_access(1, 1'b0, 16'h0010, 8'h00, 1'b0, lat, dat, er, post);
        total++; if (lat !== 4) begin bad++; $display("FAIL rstwait_lat got=%0d want=4", lat); end
        total++; if (dat !== 8'h5A) begin bad++; $display("FAIL rstwait_old got=%h want=5a", dat); end
    endtask

    task automatic test_enable_freeze();
        int lat;
        req_a[1] = 1'b1; rw_a[1] = RW_READ; addr_a[1] = 16'h1234; dout_a[1] = 8'h00;
        tick();
        tick();
        enable = 1'b0;
        for (int k = 0; k < 5; k++) begin
            tick();
            total++; if (rdy(1) !== 1'b0) begin bad++; $display("FAIL freeze_ready[%0d] got=%b want=0", k, rdy(1)); end
            total++; if (din(1) !== 8'h5A) begin bad++; $display("FAIL freeze_data[%0d] got=%h want=5a", k, din(1)); end
        end
        enable = 1'b1;
        lat = 7;
        for (int k = 0; k < 30; k++) begin
            tick();
            lat++;
            if (rdy(1)) break;
        end
        if (!rdy(1)) lat = -1;
        total++; if (lat !== 9) begin bad++; $display("FAIL freeze_lat got=%0d want=9", lat); end
        total++; if (din(1) !== 8'hA5) begin bad++; $display("FAIL freeze_rd got=%h want=a5", din(1)); end
        req_a[1] = 1'b0;
        enable = 1'b0;
        for (int k = 0; k < 2; k++) begin
            tick();
            total++; if (rdy(1) !== 1'b1) begin bad++; $display("FAIL freeze_resp[%0d] got=%b want=1", k, rdy(1)); end
        end
        enable = 1'b1;
        tick();
        total++; if (rdy(1) !== 1'b0) begin bad++; $display("FAIL freeze_after got=%b want=0", rdy(1)); end
    endtask

    task automatic test_back_to_back();
        int lat; logic [7:0] dat; logic er, post;
        do_access(1, 1'b1, 16'h0001, 8'h31, 1'b0, lat, dat, er, post);
        do_access(1, 1'b1, 16'h0002, 8'h32, 1'b0, lat, dat, er, post);
        req_a[1] = 1'b1; rw_a[1] = RW_READ; addr_a[1] = 16'h0001;
        for (int n = 0; n < 2; n++) begin
            lat = 0;
            for (int k = 0; k < 30; k++) begin
                tick();
                lat++;
                if (rdy(1)) break;
            end
            if (!rdy(1)) lat = -1;
            total++; if (lat !== (n == 0 ? 4 : 5)) begin bad++; $display("FAIL b2b_lat[%0d] got=%0d want=%0d", n, lat, (n == 0 ? 4 : 5)); end
            total++; if (din(1) !== (n == 0 ? 8'h31 : 8'h32)) begin bad++; $display("FAIL b2b_data[%0d] got=%h want=%h", n, din(1), (n == 0 ? 8'h31 : 8'h32)); end
            addr_a[1] = 16'h0002;
        end
        req_a[1] = 1'b0;
        tick();
        total++; if (rdy(1) !== 1'b0) begin bad++; $display("FAIL b2b_end got=%b want=0", rdy(1)); end
    endtask

    initial begin
        rst    = 1'b0;
        enable = 1'b1;
        for (int i = 0; i < 3; i++) begin
            req_a[i] = 1'b0; rw_a[i] = RW_READ; addr_a[i] = '0; dout_a[i] = '0;
        end
        test_reset();
        test_nowait();
        test_wait3();
        test_window();
        test_reset_in_wait();
        test_enable_freeze();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/cpu_mem_responder.md
CPU_MEM_RESPONDER -- requirements
Module: cpu_mem_responder

Interface
REQ-001 Parameter ADDR_WIDTH, default 16: CPU address bus width.
REQ-002 Parameter DATA_WIDTH, default 8: data bus width.
REQ-003 Parameter MEM_AW, default 16, range 1..ADDR_WIDTH: implemented array is 2**MEM_AW bytes at address 0 upward.
REQ-004 Parameter WAIT_STATES, default 0, range 0..15: extra cycles inserted before each access.
REQ-005 Port clk, input, 1: single clock; all logic on its rising edge.
REQ-006 Port rst, input, 1: asynchronous, active-low reset; 0 = reset.
REQ-007 Port enable, input, 1: global advance enable; same meaning as the CPU's enable.
REQ-008 Port req_rdwr, input, 1: CPU requests an access.
REQ-009 Port which_rdwr, input, 1: the shared read/write enum; READ or WRITE.
REQ-010 Port addr, input, ADDR_WIDTH: access address.
REQ-011 Port data_out, input, DATA_WIDTH: CPU write data.
REQ-012 Port data_in, output reg, DATA_WIDTH: read data returned to the CPU.
REQ-013 Port ready, output reg, 1: one-cycle completion strobe.
REQ-014 Port err, output reg, 1: one-cycle strobe, set together with ready, when the completed access was out of window.

Function
REQ-015 States: IDLE, WAIT, RESP. While enable=0, state, counter, outputs and array are all frozen.
REQ-016 IDLE, req_rdwr=0: remain in IDLE; ready=0 and err=0.
REQ-017 IDLE, req_rdwr=1: latch which_rdwr, addr and data_out.
  - WAIT_STATES=0: perform the access on this edge and go to RESP.
  - Otherwise: load the wait counter with WAIT_STATES-1 and go to WAIT.
REQ-018 WAIT: decrement the counter each enabled cycle. At counter=0, perform the access from the latched values and go to RESP. Live bus inputs are ignored in WAIT.
REQ-019 Access, in window (addr >> MEM_AW == 0):
  - WRITE: store the latched data; data_in is unchanged.
  - READ: data_in <= array[addr[MEM_AW-1:0]].
REQ-020 Access, out of window: a WRITE is dropped; a READ sets data_in to all-ones; err=1 during RESP.
REQ-021 RESP: ready=1 for exactly this one cycle, then IDLE unconditionally. A request visible during RESP is not accepted; it is sampled again in IDLE.
REQ-022 Latency, counted in enabled edges from the IDLE edge that samples the request to ready high: 1+WAIT_STATES. Throughput is one access per 2+WAIT_STATES cycles.
REQ-023 data_in holds the last read value until the next READ completes.
REQ-024 Read-after-write to the same address returns the newly written byte.
REQ-025 The CPU holds req_rdwr, which_rdwr, addr and data_out stable until it samples ready=1. This is a protocol rule for the initiator; the responder does not check it.

Reset
REQ-026 rst=0 asynchronously forces: state=IDLE, counter=0, ready=0, err=0, data_in=0.
REQ-027 Reset in WAIT aborts the access: a pending write is not performed.
REQ-028 Array contents are not reset. Simulation-only initial contents are zero.

Structure
REQ-029 The read/write enum values, the address and data width macros, and the responder state encodings live in the shared CPU include files, alongside the existing CPU enums.
REQ-030 The storage is a sub-module, cpu_mem_array: single-port, synchronous write, synchronous read. The FSM and window decode stay in cpu_mem_responder.

Verification
REQ-031 WAIT_STATES=0: write 0x45 to 0xF000, then write 0x87 to 0xF500, then read 0xF000 and 0xF500.
  - Required: data_in=0x45, then 0x87.
  - Each ready pulse arrives 1 cycle after the request is sampled.
  - err stays 0 throughout.
REQ-032 WAIT_STATES=3: read 0x1234 after writing 0xA5 there.
  - Required: ready high exactly 4 enabled cycles after the request is sampled; data_in=0xA5.
  - Changing addr during WAIT has no effect.
REQ-033 MEM_AW=12: read 0xF000 -> data_in=0xFF and err=1 with ready. Write 0x11 to 0xF000, then read 0x0000 -> the prior value is unchanged.
REQ-034 WAIT_STATES=3: write 0x99 to 0x0010, pull rst low in the second WAIT cycle, release it, then read 0x0010.
  - Required: the old value is returned.
  - ready, err and data_in are 0 immediately while rst is low.
REQ-035 Drop enable for 5 cycles mid-WAIT: state, counter and outputs are frozen, and ready arrives exactly 5 cycles later than nominal.
REQ-036 Hold req_rdwr high continuously for back-to-back reads of 0x0001 and 0x0002: one ready per 2+WAIT_STATES cycles; no request is accepted during RESP.
